// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like slave port between the core's inst and data
// masters. Each accepted request's owner is kept in an in-order FIFO so that every
// data_ok/rdata returns to the master that issued it. In-flight requests are capped
// at OUTSTANDING.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration in IDLE; otherwise
// data always beats inst.
module sram_req_arbiter #(
   parameter int unsigned OUTSTANDING = 4
) (
   input  logic        aclk,
   input  logic        aresetn,
   // master 0: inst
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   input  logic [3:0]  inst_wstrb,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // master 1: data
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wstrb,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // shared slave port
   output logic        s_req,
   output logic        s_wr,
   output logic [1:0]  s_size,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_addr_ok,
   input  logic        s_data_ok,
   input  logic [31:0] s_rdata,
   output logic        resp_err
);

   localparam int unsigned PtrW = $clog2(OUTSTANDING);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic OwnInst = 1'b0;
   localparam logic OwnData = 1'b1;

   typedef enum logic [0:0] {StIdle, StLock} state_e;

   state_e                 state_q, state_d;
   logic                   grant_q, grant_d;
   logic [OUTSTANDING-1:0] owner_q, owner_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   resp_err_q, resp_err_d;

   logic full, any_req, winner, grant, req_raw, push, pop, pop_owner;

`ifdef SRAM_ARB_RR_EN
   logic rr_last_q, rr_last_d;
`endif

   assign full    = (count_q == CntW'(OUTSTANDING));
   assign any_req = inst_req | data_req;

   // Pick the master that would be granted if no grant is locked
   always_comb begin
`ifdef SRAM_ARB_RR_EN
      if (inst_req && data_req) begin
         winner = ~rr_last_q;
      end else begin
         winner = data_req ? OwnData : OwnInst;
      end
`else
      winner = data_req ? OwnData : OwnInst;
`endif
   end

   // State and locked grant register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= StIdle;
         grant_q <= OwnInst;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   // Lock the grant when the slave does not accept in the cycle it is offered
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      unique case (state_q)
         StIdle: begin
            if (req_raw && !s_addr_ok) begin
               state_d = StLock;
               grant_d = winner;
            end
         end
         StLock: begin
            if (s_addr_ok) state_d = StIdle;
         end
      endcase
   end

   // Current grantee and raw slave request
   always_comb begin
      grant   = grant_q;
      req_raw = 1'b0;
      unique case (state_q)
         StIdle: begin
            grant   = winner;
            req_raw = any_req && !full;
         end
         StLock: begin
            // A locked request is never withdrawn; full cannot occur while locked
            grant   = grant_q;
            req_raw = 1'b1;
         end
      endcase
   end

   // Everything visible is forced low while reset is held, even with inputs active
   assign s_req     = req_raw & aresetn;
   assign push      = s_req & s_addr_ok;
   assign pop       = s_data_ok & aresetn & (count_q != '0);
   assign pop_owner = owner_q[rd_ptr_q];

   assign inst_addr_ok = push & (grant == OwnInst);
   assign data_addr_ok = push & (grant == OwnData);
   assign inst_data_ok = pop & (pop_owner == OwnInst);
   assign data_data_ok = pop & (pop_owner == OwnData);
   assign inst_rdata   = aresetn ? s_rdata : '0;
   assign data_rdata   = aresetn ? s_rdata : '0;

   assign s_wr    = s_req & ((grant == OwnData) ? data_wr : inst_wr);
   assign s_size  = s_req ? ((grant == OwnData) ? data_size  : inst_size)  : '0;
   assign s_addr  = s_req ? ((grant == OwnData) ? data_addr  : inst_addr)  : '0;
   assign s_wdata = s_req ? ((grant == OwnData) ? data_wdata : inst_wdata) : '0;
   assign s_wstrb = s_req ? ((grant == OwnData) ? data_wstrb : inst_wstrb) : '0;
   assign resp_err = resp_err_q;

   // Owner FIFO, occupancy and sticky error next-state
   always_comb begin
      owner_d    = owner_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      resp_err_d = resp_err_q | (s_data_ok & aresetn & (count_q == '0));
      if (push) begin
         owner_d[wr_ptr_q] = grant;
         wr_ptr_d          = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO and error registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         owner_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         resp_err_q <= resp_err_d;
      end
   end

`ifdef SRAM_ARB_RR_EN
   // Remember the last master to complete a handshake
   always_comb begin
      rr_last_d = push ? grant : rr_last_q;
   end

   // Round-robin history register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rr_last_q <= OwnInst;
      else          rr_last_q <= rr_last_d;
   end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter: random masters and a random in-order slave, a
// queue-based reference model predicting grants and owners, and a response
// scoreboard drained by a separate monitor.
module tb_sram_req_arbiter;

   localparam int unsigned OUTSTANDING = 4;
`ifdef SRAM_ARB_RR_EN
   localparam bit UseRr = 1'b1;
`else
   localparam bit UseRr = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata, inst_rdata;
   logic [3:0]  inst_wstrb;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic        s_req, s_wr, s_addr_ok, s_data_ok, resp_err;
   logic [1:0]  s_size;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;

   sram_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_wstrb(inst_wstrb), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
      .resp_err(resp_err)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } pay_t;

   typedef struct {
      int          owner;   // 0 = inst, 1 = data
      logic [31:0] rdata;
   } resp_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   resp_t       sb_q[$];        // responses the DUT owes, in order
   int          model_q[$];     // owners of accepted, unanswered requests
   logic [31:0] slv_data_q[$];  // slave read data per accepted request
   int          slv_ready_q[$]; // earliest cycle each response may return
   int          locked = -1;    // master already offered but not yet accepted
   int          rr_last = 0;
   logic        req[2];
   pay_t        pay[2];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic pay_t rand_pay();
      pay_t p;
      p.wr    = 1'($urandom_range(1));
      p.size  = 2'($urandom_range(2));
      p.addr  = $urandom();
      p.wdata = $urandom();
      p.wstrb = 4'($urandom_range(15));
      return p;
   endfunction

   task automatic drive();
      inst_req = req[0];
      {inst_wr, inst_size, inst_addr, inst_wdata, inst_wstrb} = pay[0];
      data_req = req[1];
      {data_wr, data_size, data_addr, data_wdata, data_wstrb} = pay[1];
   endtask

   task automatic model_reset();
      model_q.delete();
      slv_data_q.delete();
      slv_ready_q.delete();
      locked  = -1;
      rr_last = 0;
      req[0]  = 1'b0;
      req[1]  = 1'b0;
   endtask

   // One random cycle; entered #1 after a rising edge
   task automatic step(input int p_new, input int p_aok, input int p_dok);
      int   g;
      logic dok;
      resp_t r;
      for (int m = 0; m < 2; m++) begin
         if (!req[m] && $urandom_range(99) < p_new) begin
            req[m] = 1'b1;
            pay[m] = rand_pay();
         end
      end
      drive();
      s_addr_ok = ($urandom_range(99) < p_aok);
      dok = (slv_data_q.size() > 0) && (slv_ready_q[0] <= cyc) && ($urandom_range(99) < p_dok);
      s_data_ok = dok;
      s_rdata   = dok ? slv_data_q[0] : $urandom();
      // Who the slave port should serve this cycle
      g = -1;
      if (locked >= 0) begin
         g = locked;
      end else if (model_q.size() < OUTSTANDING) begin
         if (req[0] && req[1]) g = UseRr ? (1 - rr_last) : 1;
         else if (req[1])      g = 1;
         else if (req[0])      g = 0;
      end
      if (dok) begin
         r.owner = model_q[0];
         r.rdata = slv_data_q[0];
         sb_q.push_back(r);
      end
      @(negedge aclk);
      check("s_req", s_req, g >= 0);
      check("inst_addr_ok", inst_addr_ok, (g == 0) && s_addr_ok);
      check("data_addr_ok", data_addr_ok, (g == 1) && s_addr_ok);
      if (g >= 0) check("s_payload", {s_wr, s_size, s_addr, s_wdata, s_wstrb}, pay[g]);
      check("any_data_ok", inst_data_ok | data_data_ok, dok);
      check("resp_err_clear", resp_err, 1'b0);
      if (dok) begin
         void'(model_q.pop_front());
         void'(slv_data_q.pop_front());
         void'(slv_ready_q.pop_front());
      end
      if (g >= 0 && s_addr_ok) begin
         model_q.push_back(g);
         slv_data_q.push_back($urandom());
         slv_ready_q.push_back(cyc + 1);
         req[g]  = 1'b0;
         rr_last = g;
         locked  = -1;
      end else begin
         locked = g;
      end
      @(posedge aclk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (i < 500 && (model_q.size() != 0 || req[0] || req[1])) begin
         step(0, 100, 100);
         i++;
      end
      check("drain_done", model_q.size() + int'(req[0]) + int'(req[1]), 0);
      check("scoreboard_empty", sb_q.size(), 0);
   endtask

   // Response monitor: every data_ok pulse must match the oldest owed response
   always @(negedge aclk) begin
      resp_t r;
      if (aresetn === 1'b1 && (inst_data_ok || data_data_ok)) begin
         if (sb_q.size() == 0) begin
            check("data_ok_unexpected", {inst_data_ok, data_data_ok}, 2'b00);
         end else begin
            r = sb_q.pop_front();
            check("data_ok_owner", {inst_data_ok, data_data_ok}, (r.owner == 1) ? 2'b01 : 2'b10);
            check("rdata", (r.owner == 1) ? data_rdata : inst_rdata, r.rdata);
         end
      end
   end

   initial begin
      model_reset();
      pay[0] = rand_pay();
      pay[1] = rand_pay();
      // Reset with every input active: outputs must stay low
      aresetn = 1'b0;
      req[0] = 1'b1;
      req[1] = 1'b1;
      drive();
      s_addr_ok = 1'b1;
      s_data_ok = 1'b1;
      s_rdata   = 32'h3C1D_0000;
      #2;
      check("rst_s_req", s_req, 1'b0);
      check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      check("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      check("rst_resp_err", resp_err, 1'b0);
      check("rst_s_addr", s_addr, 32'h0);
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      model_reset();
      drive();
      s_addr_ok = 1'b0;
      s_data_ok = 1'b0;
      aresetn   = 1'b1;
      @(posedge aclk);
      #1;

      // Busy traffic, then a slow-responding slave so the FIFO fills
      repeat (1500) step(60, 60, 50);
      repeat (1000) step(90, 90, 8);
      drain();

      // Response with nothing outstanding raises the sticky error
      s_addr_ok = 1'b0;
      s_data_ok = 1'b1;
      s_rdata   = 32'h5A5A_5A5A;
      @(negedge aclk);
      check("stray_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      check("resp_err_pre", resp_err, 1'b0);
      @(posedge aclk);
      #1;
      s_data_ok = 1'b0;
      @(negedge aclk);
      check("resp_err_set", resp_err, 1'b1);
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("resp_err_held", resp_err, 1'b1);

      // Two accepts then a stall, and reset lands mid-burst
      @(posedge aclk);
      #1;
      pay[0] = rand_pay();
      pay[1] = rand_pay();
      req[0] = 1'b1;
      req[1] = 1'b1;
      drive();
      s_addr_ok = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      s_addr_ok = 1'b0;
      @(posedge aclk);
      #2;
      aresetn   = 1'b0;
      s_addr_ok = 1'b1;
      s_data_ok = 1'b1;
      s_rdata   = 32'hDEAD_BEEF;
      #1;
      check("mid_rst_s_req", s_req, 1'b0);
      check("mid_rst_payload", {s_wr, s_size, s_addr, s_wdata, s_wstrb}, 71'h0);
      check("mid_rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      check("mid_rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      check("mid_rst_rdata", {inst_rdata, data_rdata}, 64'h0);
      check("mid_rst_resp_err", resp_err, 1'b0);
      @(negedge aclk);
      model_reset();
      drive();
      s_addr_ok = 1'b0;
      s_data_ok = 1'b0;
      aresetn   = 1'b1;
      @(posedge aclk);
      #1;

      // Traffic after reset relies on owners, pointers and count restarting cleanly
      repeat (400) step(70, 50, 40);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
